// File: rtl/mult_hilo_sequencer.sv
// Iterative shift-add multiplier for mul/mult/multu/madd/msub, producing a 2*WIDTH
// result for HI/LO (or the low half for the GPR) after WIDTH/RADIX_BITS iterations.
module mult_hilo_sequencer #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             hilo_write,
    output logic             gpr_write,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int PW    = 2 * WIDTH;
    localparam int N     = WIDTH / RADIX_BITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULT = 2'b01,
        OP_MADD = 2'b10,
        OP_MSUB = 2'b11
    } op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    hilo_q, hilo_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PW-1:0]    res_q, res_d;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    product;
    logic [PW-1:0]    result;

    // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct magnitude.
    assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    always_comb begin
        pp = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            if (mplier_q[i]) begin
                pp = pp + (mcand_q << i);
            end
        end
    end

    assign product = neg_q ? -acc_q : acc_q;

    always_comb begin
        unique case (op_q)
            OP_MADD: result = hilo_q + product;
            OP_MSUB: result = hilo_q - product;
            default: result = product;
        endcase
    end

    // NOTE: every _d gets its _q as a default first, so no path leaves a latch behind.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        hilo_d   = hilo_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        res_d    = res_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d     = op_t'(op);
                        neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        hilo_d   = {hi_in, lo_in};
                        mcand_d  = {{WIDTH{1'b0}}, a_mag};
                        mplier_d = b_mag;
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = S_ITER;
                    end
                end
                S_ITER: begin
                    acc_d    = acc_q + pp;
                    mcand_d  = mcand_q << RADIX_BITS;
                    mplier_d = mplier_q >> RADIX_BITS;
                    count_d  = count_q + CNT_W'(1);
                    if (count_q == LAST_COUNT) begin
                        state_d = S_FIN;
                    end
                end
                S_FIN: begin
                    res_d   = result;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            hilo_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            hilo_q   <= hilo_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            res_q    <= res_d;
        end
    end

    // A flush landing in DONE must suppress the write pulse in that same cycle.
    assign busy       = (state_q == S_ITER) || (state_q == S_FIN);
    assign done       = (state_q == S_DONE) && !flush;
    assign hilo_write = done && (op_q != OP_MUL);
    assign gpr_write  = done && (op_q == OP_MUL);
    assign hi_out     = res_q[PW-1:WIDTH];
    assign lo_out     = res_q[WIDTH-1:0];

endmodule

// File: tb/tb_mult_hilo_sequencer.sv
// Directed bench for mult_hilo_sequencer: a radix-1 and a radix-4 instance share stimulus.
module tb_mult_hilo_sequencer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        start;
    logic        flush;
    logic        is_signed;
    logic [1:0]  op;
    logic [31:0] a, b, hi_in, lo_in;

    logic        busy1, done1, hw1, gw1;
    logic [31:0] hi1, lo1;
    logic        busy4, done4, hw4, gw4;
    logic [31:0] hi4, lo4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    always #5 Clk = ~Clk;

    mult_hilo_sequencer #(.WIDTH(32), .RADIX_BITS(1)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .op(op), .is_signed(is_signed),
        .a(a), .b(b), .hi_in(hi_in), .lo_in(lo_in), .flush(flush),
        .busy(busy1), .done(done1), .hilo_write(hw1), .gpr_write(gw1),
        .hi_out(hi1), .lo_out(lo1)
    );

    mult_hilo_sequencer #(.WIDTH(32), .RADIX_BITS(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .start(start), .op(op), .is_signed(is_signed),
        .a(a), .b(b), .hi_in(hi_in), .lo_in(lo_in), .flush(flush),
        .busy(busy4), .done(done4), .hilo_write(hw4), .gpr_write(gw4),
        .hi_out(hi4), .lo_out(lo4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        op        = v.op;
        is_signed = v.sgn;
        a         = v.a;
        b         = v.b;
        hi_in     = v.hi;
        lo_in     = v.lo;
    endtask

    // Start one operation and follow both instances until the radix-1 one signals done.
    task automatic run_vec(input vec_t v, input string tag);
        int          lat1 = 0;
        int          lat4 = 0;
        int          bcnt = 0;
        logic [63:0] r1 = '0;
        logic [63:0] r4 = '0;
        logic        h1 = 1'b0;
        logic        g1 = 1'b0;
        drive(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (busy1) bcnt++;
        for (int e = 1; e <= 60 && lat1 == 0; e++) begin
            tick();
            if (busy1) bcnt++;
            if (done4 && lat4 == 0) begin
                lat4 = e;
                r4   = {hi4, lo4};
            end
            if (done1) begin
                lat1 = e;
                r1   = {hi1, lo1};
                h1   = hw1;
                g1   = gw1;
            end
        end
        tick();
        check({tag, "_result"},     r1, v.exp);
        check({tag, "_hilo_write"}, 64'(h1), 64'(v.op != 2'b00));
        check({tag, "_gpr_write"},  64'(g1), 64'(v.op == 2'b00));
        check({tag, "_done_edge"},  64'(lat1), 64'd33);
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'd33);
        check({tag, "_r4_result"},  r4, v.exp);
        check({tag, "_r4_done_edge"}, 64'(lat4), 64'd9);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b01, 1'b1, 32'hFFFF_FFFD, 32'd7,        32'h0, 32'h0,         64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1] = '{2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,        64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{2'b01, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0,        64'h4000_0000_0000_0000};
        vecs[3] = '{2'b01, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0,        64'h4000_0000_0000_0000};
        vecs[4] = '{2'b10, 1'b1, 32'd1,         32'd1,         32'h0, 32'hFFFF_FFFF, 64'h0000_0001_0000_0000};
        vecs[5] = '{2'b11, 1'b1, 32'd2,         32'd3,         32'h0, 32'h0,        64'hFFFF_FFFF_FFFF_FFFA};
        vecs[6] = '{2'b00, 1'b1, 32'd12345,     32'd1000,      32'h0, 32'h0,        64'h0000_0000_00BC_5EA8};
        vecs[7] = '{2'b10, 1'b1, 32'hFFFF_FFFE, 32'd5,         32'h0, 32'd100,      64'h0000_0000_0000_005A};

        Rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        drive(vecs[0]);
        tick();
        tick();
        check("reset_hilo_out", {hi1, lo1}, 64'h0);
        check("reset_ctl", 64'({busy1, done1, hw1, gw1, busy4, done4, hw4, gw4}), 64'h0);
        Rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // mul with a stray start while busy: exactly one completion from each instance.
        begin
            int dc1 = 0;
            int dc4 = 0;
            drive(vecs[6]);
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int e = 1; e <= 80; e++) begin
                tick();
                if (e == 4) start = 1'b1;
                if (e == 5) start = 1'b0;
                if (done1) dc1++;
                if (done4) dc4++;
            end
            check("mul_restart_done_count", 64'(dc1), 64'd1);
            check("mul_restart_r4_done_count", 64'(dc4), 64'd1);
            check("mul_restart_result", {hi1, lo1}, 64'h0000_0000_00BC_5EA8);
        end

        // Flush mid-ITER with a simultaneous start: back to IDLE, outputs untouched.
        begin
            int seen_done = 0;
            vec_t v = '{2'b01, 1'b1, 32'd5, 32'd6, 32'h0, 32'h0, 64'd30};
            drive(v);
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int e = 1; e <= 10; e++) begin
                tick();
                if (done1 || hw1) seen_done++;
            end
            flush = 1'b1;
            start = 1'b1;
            tick();
            flush = 1'b0;
            start = 1'b0;
            check("flush_iter_busy", 64'(busy1), 64'd0);
            check("flush_iter_no_done", 64'(seen_done + int'(done1) + int'(hw1)), 64'd0);
            check("flush_iter_outputs_held", {hi1, lo1}, 64'h0000_0000_00BC_5EA8);
            run_vec(vecs[0], "after_flush");
        end

        // Asynchronous reset in the middle of ITER.
        begin
            drive(vecs[1]);
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int e = 1; e <= 5; e++) tick();
            #3;
            Rst = 1'b1;
            #1;
            check("rst_mid_busy", 64'({busy1, busy4}), 64'd0);
            check("rst_mid_outputs", {hi1, lo1}, 64'h0);
            check("rst_mid_pulses", 64'({done1, hw1, gw1, done4, hw4, gw4}), 64'd0);
            Rst = 1'b0;
            tick();
            check("rst_mid_stays_idle", 64'({busy1, done1}), 64'd0);
        end

        // Flush while in DONE: write pulse suppressed, the FIN result stays on the outputs.
        begin
            int found = 0;
            drive(vecs[4]);
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int e = 1; e <= 60 && found == 0; e++) begin
                tick();
                if (done1) found = e;
            end
            check("flush_done_reached", 64'(found), 64'd33);
            flush = 1'b1;
            #1;
            check("flush_done_pulses", 64'({done1, hw1, gw1}), 64'd0);
            tick();
            flush = 1'b0;
            check("flush_done_idle", 64'({busy1, done1, hw1}), 64'd0);
            check("flush_done_result_kept", {hi1, lo1}, vecs[4].exp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
